// File: rtl/prienc_pkg.sv
// Shared types and constants for the registered N-input priority arbiter.
package prienc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prienc_search.sv
// Combinational rotated search: scans start, start-1, ..., 0, N-1, ... and reports
// the first set request. Fixed mode always starts at N-1 (plain highest-index-first).
module prienc_search
    import prienc_pkg::*;
#(
    parameter  int unsigned N     = 8,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    input  logic             mode,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] first;
    logic [IDX_W-1:0] pos;

    // Walk the order back to front so the earliest position in the order wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        first = (mode == MODE_RR) ? start : IDX_W'(N - 1);
        for (int i = int'(N) - 1; i >= 0; i--) begin
            pos = IDX_W'((int'(first) + int'(N) - i) % int'(N));
            if (req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/prienc_arb_n.sv
// Registered N-input arbiter with sticky grant held until ack; fixed-priority or
// round-robin selection, one idle bubble between consecutive grants.
module prienc_arb_n
    import prienc_pkg::*;
#(
    parameter  int unsigned N     = 8,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [N-1:0]     req,
    input  logic             ack,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt_onehot
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             gnt_mode_q, gnt_mode_d;
    logic             valid_d;
    logic [IDX_W-1:0] idx_d;
    logic [N-1:0]     onehot_d;
    logic             found;
    logic [IDX_W-1:0] win;

    prienc_search #(.N(N)) u_search (
        .req   (req),
        .start (rr_ptr_q),
        .mode  (mode),
        .found (found),
        .idx   (win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= IDX_W'(N - 1);
            gnt_mode_q <= MODE_FIXED;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_mode_q <= gnt_mode_d;
            gnt_valid  <= valid_d;
            gnt_idx    <= idx_d;
            gnt_onehot <= onehot_d;
        end
    end

    // Mode is latched with the grant so the pointer update follows the arbitration mode.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_mode_d = gnt_mode_q;
        valid_d    = gnt_valid;
        idx_d      = gnt_idx;
        onehot_d   = gnt_onehot;
        unique case (state_q)
            IDLE: begin
                valid_d  = 1'b0;
                onehot_d = '0;
                if (found) begin
                    state_d    = GRANT;
                    gnt_mode_d = mode;
                    valid_d    = 1'b1;
                    idx_d      = win;
                    onehot_d   = N'(1) << win;
                end
            end
            GRANT: begin
                if (ack) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    onehot_d = '0;
                    if (gnt_mode_q == MODE_RR) begin
                        rr_ptr_d = (gnt_idx == '0) ? IDX_W'(N - 1) : gnt_idx - IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prienc_arb_n.sv
// Bench for prienc_arb_n: directed vector table, hand sequences and random traffic
// checked against a transaction-level reference model.
module tb_prienc_arb_n;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = $clog2(N);

    logic             clk;
    logic             rst;
    logic             mode;
    logic [N-1:0]     req;
    logic             ack;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [N-1:0]     gnt_onehot;

    int tests = 0;
    int fails = 0;

    // Reference model: is a grant outstanding, who holds it, and the round-robin pointer.
    bit m_busy  = 1'b0;
    int m_idx   = 0;
    int m_ptr   = N - 1;
    bit m_gmode = 1'b0;

    typedef struct {
        logic             rst;
        logic             mode;
        logic [N-1:0]     req;
        logic             ack;
        logic             exp_valid;
        logic [IDX_W-1:0] exp_idx;
        logic [N-1:0]     exp_onehot;
    } vec_t;

    vec_t vecs[12];
    int   rr_exp[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

    prienc_arb_n #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .req        (req),
        .ack        (ack),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build the candidate order explicitly, then take the first requester in it.
    function automatic int pick(logic [N-1:0] r, logic m, int ptr);
        int order[$];
        int start;
        start = m ? ptr : N - 1;
        for (int k = 0; k < N; k++) order.push_back((start - k + N) % N);
        foreach (order[j]) begin
            if (((r >> order[j]) & N'(1)) != '0) return order[j];
        end
        return -1;
    endfunction

    task automatic check(string name, logic v, logic [IDX_W-1:0] i, logic [N-1:0] oh);
        tests++;
        if (gnt_valid !== v || gnt_idx !== i || gnt_onehot !== oh) begin
            fails++;
            $display("FAIL %s @%0t: got valid=%0b idx=%0d onehot=%02h, want valid=%0b idx=%0d onehot=%02h",
                     name, $time, gnt_valid, gnt_idx, gnt_onehot, v, i, oh);
        end
    endtask

    task automatic step(logic rs, logic md, logic [N-1:0] r, logic a);
        int w;
        rst  = rs;
        mode = md;
        req  = r;
        ack  = a;
        @(posedge clk);
        if (rs) begin
            m_busy = 1'b0; m_idx = 0; m_ptr = N - 1; m_gmode = 1'b0;
        end else if (!m_busy) begin
            w = pick(r, md, m_ptr);
            if (w >= 0) begin
                m_busy = 1'b1; m_idx = w; m_gmode = md;
            end
        end else if (a) begin
            m_busy = 1'b0;
            if (m_gmode) m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
        end
        #1;
        check("model", m_busy, IDX_W'(m_idx), m_busy ? (N'(1) << m_idx) : '0);
        @(negedge clk);
    endtask

    task automatic expect_grant(string name, int k);
        check(name, 1'b1, IDX_W'(k), N'(1) << k);
    endtask

    task automatic expect_idle(string name, int k);
        check(name, 1'b0, IDX_W'(k), '0);
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; req = '0; ack = 1'b0;

        // Reset with all requests, release, then fixed-mode sticky grant and release.
        vecs[0]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 8'h25, 1'b0, 1'b1, 3'd5, 8'h20};
        vecs[5]  = '{1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 3'd5, 8'h20};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd5, 8'h20};
        vecs[7]  = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 3'd5, 8'h20};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 8'h02, 1'b0, 1'b1, 3'd1, 8'h02};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00};

        @(negedge clk);
        for (int v = 0; v < 12; v++) begin
            step(vecs[v].rst, vecs[v].mode, vecs[v].req, vecs[v].ack);
            check("table", vecs[v].exp_valid, vecs[v].exp_idx, vecs[v].exp_onehot);
        end

        // Round-robin rotation with all requesters active.
        step(1'b1, 1'b1, 8'h00, 1'b0);
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 1'b1, 8'hFF, 1'b0);
            expect_grant("rr_seq", rr_exp[k]);
            step(1'b0, 1'b1, 8'hFF, 1'b1);
            expect_idle("rr_bubble", rr_exp[k]);
        end

        // Pointer wrap: grant 0 -> ptr 7 -> grant 7 -> ptr 6 -> grant 0.
        step(1'b1, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h01, 1'b0);
        expect_grant("wrap_g0", 0);
        step(1'b0, 1'b1, 8'h81, 1'b1);
        step(1'b0, 1'b1, 8'h81, 1'b0);
        expect_grant("wrap_g7", 7);
        step(1'b0, 1'b1, 8'h81, 1'b1);
        step(1'b0, 1'b1, 8'h81, 1'b0);
        expect_grant("wrap_g0b", 0);
        step(1'b0, 1'b1, 8'h00, 1'b1);

        // Reset mid-grant drops the grant and restores the pointer to N-1.
        step(1'b0, 1'b1, 8'h08, 1'b0);
        expect_grant("mid_g3", 3);
        step(1'b0, 1'b1, 8'h08, 1'b1);
        step(1'b0, 1'b1, 8'h08, 1'b0);
        expect_grant("mid_g3b", 3);
        step(1'b1, 1'b1, 8'h08, 1'b0);
        expect_idle("mid_rst", 0);
        step(1'b0, 1'b1, 8'h09, 1'b0);
        expect_grant("mid_after", 3);
        step(1'b0, 1'b1, 8'h00, 1'b1);

        // Fixed grants leave the pointer alone; mode changes in GRANT are ignored.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h10, 1'b0);
        expect_grant("fix_g4", 4);
        step(1'b0, 1'b0, 8'h10, 1'b1);
        step(1'b0, 1'b1, 8'h18, 1'b0);
        expect_grant("rr_after_fix", 4);
        step(1'b0, 1'b0, 8'h81, 1'b0);
        expect_grant("mode_hold", 4);
        step(1'b0, 1'b0, 8'h02, 1'b1);
        expect_idle("ack_req_bubble", 4);
        step(1'b0, 1'b0, 8'h02, 1'b0);
        expect_grant("ack_req_g1", 1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? '0 : N'($urandom),
                 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
